// File: rtl/render_pipeline_pkg.sv
// Shared types and constants for the render pipeline: triangle assembler FSM
// state and the guard bits that size the signed double-area result.
package render_pipeline_pkg;

  typedef enum logic [1:0] {
    TA_COLLECT = 2'd0,
    TA_SETUP   = 2'd1,
    TA_OUTPUT  = 2'd2
  } triangle_assembler_state_t;

  // Two products of (DATAWIDTH+1)-bit differences, then their difference.
  localparam int TA_AREA_GUARD_BITS = 2;

  function automatic int ta_area_width(input int datawidth);
    return 2 * datawidth + TA_AREA_GUARD_BITS;
  endfunction

endpackage

// File: rtl/triangle_bbox.sv
// Bounding box of three screen vertices: raw min/max, clamp to the screen and
// a flag for boxes lying entirely outside it.
module triangle_bbox #(
  parameter int DATAWIDTH     = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320
) (
  input  logic signed [DATAWIDTH-1:0] x         [3],
  input  logic signed [DATAWIDTH-1:0] y         [3],
  output logic signed [DATAWIDTH-1:0] bbox_min  [2],
  output logic signed [DATAWIDTH-1:0] bbox_max  [2],
  output logic                        offscreen
);

  localparam logic signed [DATAWIDTH-1:0] X_LIM = DATAWIDTH'(SCREEN_WIDTH - 1);
  localparam logic signed [DATAWIDTH-1:0] Y_LIM = DATAWIDTH'(SCREEN_HEIGHT - 1);

  function automatic logic signed [DATAWIDTH-1:0] min3(
    input logic signed [DATAWIDTH-1:0] a, b, c);
    logic signed [DATAWIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] max3(
    input logic signed [DATAWIDTH-1:0] a, b, c);
    logic signed [DATAWIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] clamp(
    input logic signed [DATAWIDTH-1:0] v, lim);
    if (v < 0)        return '0;
    else if (v > lim) return lim;
    else              return v;
  endfunction

  logic signed [DATAWIDTH-1:0] raw_min_x, raw_max_x, raw_min_y, raw_max_y;

  always_comb begin
    raw_min_x   = min3(x[0], x[1], x[2]);
    raw_max_x   = max3(x[0], x[1], x[2]);
    raw_min_y   = min3(y[0], y[1], y[2]);
    raw_max_y   = max3(y[0], y[1], y[2]);
    bbox_min[0] = clamp(raw_min_x, X_LIM);
    bbox_min[1] = clamp(raw_min_y, Y_LIM);
    bbox_max[0] = clamp(raw_max_x, X_LIM);
    bbox_max[1] = clamp(raw_max_y, Y_LIM);
    // Tested on the raw box: a clamped box always overlaps the screen.
    offscreen   = (raw_max_x < 0) || (raw_min_x > X_LIM) ||
                  (raw_max_y < 0) || (raw_min_y > Y_LIM);
  end

endmodule

// File: rtl/triangle_assembler.sv
// Collects three vertices, computes double area and clamped bbox, culls or emits.
// TRIANGLE_ASSEMBLER_BACKFACE_CULL_EN: cull negative-area triangles instead of re-winding them.
module triangle_assembler
  import render_pipeline_pkg::*;
#(
  parameter  int DATAWIDTH      = 12,
  parameter  int DEPTH_FRACBITS = 11,
  parameter  int SCREEN_WIDTH   = 320,
  parameter  int SCREEN_HEIGHT  = 320,
  localparam int AW             = ta_area_width(DATAWIDTH),
  localparam int ZW             = DEPTH_FRACBITS + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [DATAWIDTH-1:0] i_vertex_pixel [2],
  input  logic signed [ZW-1:0]        i_vertex_z,
  input  logic                        i_vertex_dv,
  input  logic                        i_vertex_invalid,
  input  logic                        i_flush,
  output logic                        o_ready,
  output logic signed [DATAWIDTH-1:0] o_tri_pixel [3][2],
  output logic signed [ZW-1:0]        o_tri_z [3],
  output logic signed [DATAWIDTH-1:0] o_bbox_min [2],
  output logic signed [DATAWIDTH-1:0] o_bbox_max [2],
  output logic signed [AW-1:0]        o_area,
  output logic                        o_tri_dv,
  input  logic                        i_ready,
  output logic [15:0]                 o_cull_count,
  output triangle_assembler_state_t   o_state
);

  // Handshakes: a vertex transfers on a cycle with i_vertex_dv && o_ready; a
  // triangle transfers on a cycle with o_tri_dv && i_ready. Each producer holds
  // its payload stable until the transfer cycle.

  triangle_assembler_state_t state, state_next;

  logic signed [DATAWIDTH-1:0] slot_pixel [3][2];
  logic signed [ZW-1:0]        slot_z [3];
  logic [1:0]                  idx;
  logic                        invalid;

  logic                        accept;
  logic signed [AW-1:0]        dx1, dy1, dx2, dy2, area_raw;
  logic                        area_neg, cull, swap;
  logic signed [DATAWIDTH-1:0] tri_x [3];
  logic signed [DATAWIDTH-1:0] tri_y [3];
  logic signed [DATAWIDTH-1:0] bbox_min [2];
  logic signed [DATAWIDTH-1:0] bbox_max [2];
  logic                        offscreen;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tri_x[i] = slot_pixel[i][0];
      tri_y[i] = slot_pixel[i][1];
    end
  end

  triangle_bbox #(
    .DATAWIDTH    (DATAWIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_bbox (
    .x        (tri_x),
    .y        (tri_y),
    .bbox_min (bbox_min),
    .bbox_max (bbox_max),
    .offscreen(offscreen)
  );

  // Sign-extend before subtracting so the products cannot overflow AW bits.
  always_comb begin
    dx1      = AW'(slot_pixel[1][0]) - AW'(slot_pixel[0][0]);
    dy1      = AW'(slot_pixel[1][1]) - AW'(slot_pixel[0][1]);
    dx2      = AW'(slot_pixel[2][0]) - AW'(slot_pixel[0][0]);
    dy2      = AW'(slot_pixel[2][1]) - AW'(slot_pixel[0][1]);
    area_raw = dx1 * dy2 - dx2 * dy1;
    area_neg = area_raw[AW-1];
`ifdef TRIANGLE_ASSEMBLER_BACKFACE_CULL_EN
    cull     = invalid || (area_raw == '0) || offscreen || area_neg;
    swap     = 1'b0;
`else
    cull     = invalid || (area_raw == '0) || offscreen;
    swap     = area_neg;
`endif
  end

  always_comb begin
    state_next = state;
    accept     = (state == TA_COLLECT) && i_vertex_dv && !i_flush;
    case (state)
      TA_COLLECT: if (accept && idx == 2'd2) state_next = TA_SETUP;
      TA_SETUP:   state_next = cull ? TA_COLLECT : TA_OUTPUT;
      TA_OUTPUT:  if (i_ready) state_next = TA_COLLECT;
      default:    state_next = TA_COLLECT;
    endcase
  end

  assign o_ready  = (state == TA_COLLECT);
  assign o_tri_dv = (state == TA_OUTPUT);
  assign o_state  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= TA_COLLECT;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_pixel   <= '{default: '0};
      slot_z       <= '{default: '0};
      idx          <= 2'd0;
      invalid      <= 1'b0;
      o_tri_pixel  <= '{default: '0};
      o_tri_z      <= '{default: '0};
      o_bbox_min   <= '{default: '0};
      o_bbox_max   <= '{default: '0};
      o_area       <= '0;
      o_cull_count <= '0;
    end else begin
      if (state == TA_COLLECT) begin
        if (i_flush) begin
          idx     <= 2'd0;
          invalid <= 1'b0;
        end else if (i_vertex_dv) begin
          slot_pixel[idx][0] <= i_vertex_pixel[0];
          slot_pixel[idx][1] <= i_vertex_pixel[1];
          slot_z[idx]        <= i_vertex_z;
          invalid            <= invalid | i_vertex_invalid;
          idx                <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
      end
      if (state == TA_SETUP) begin
        // Swapping slots 1 and 2 flips the winding so the emitted area is positive.
        o_tri_pixel[0] <= slot_pixel[0];
        o_tri_pixel[1] <= swap ? slot_pixel[2] : slot_pixel[1];
        o_tri_pixel[2] <= swap ? slot_pixel[1] : slot_pixel[2];
        o_tri_z[0]     <= slot_z[0];
        o_tri_z[1]     <= swap ? slot_z[2] : slot_z[1];
        o_tri_z[2]     <= swap ? slot_z[1] : slot_z[2];
        o_bbox_min     <= bbox_min;
        o_bbox_max     <= bbox_max;
        o_area         <= swap ? -area_raw : area_raw;
        invalid        <= 1'b0;
        if (cull && o_cull_count != 16'hFFFF) o_cull_count <= o_cull_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed and random bench for triangle_assembler with an expected-triangle queue.
module tb_triangle_assembler;
  import render_pipeline_pkg::*;

  localparam int DW = 12;
  localparam int ZW = 12;
  localparam int AW = 26;
  localparam int SW = 320;
  localparam int SH = 320;
  localparam int PW = 10 * DW + 3 * ZW + AW + 2 * DW;

  logic                 clk;
  logic                 rstn;
  logic signed [DW-1:0] v_px [2];
  logic signed [ZW-1:0] v_z;
  logic                 v_dv;
  logic                 v_inv;
  logic                 flush;
  logic                 o_ready;
  logic signed [DW-1:0] o_tri_pixel [3][2];
  logic signed [ZW-1:0] o_tri_z [3];
  logic signed [DW-1:0] o_bbox_min [2];
  logic signed [DW-1:0] o_bbox_max [2];
  logic signed [AW-1:0] o_area;
  logic                 o_tri_dv;
  logic                 i_ready;
  logic [15:0]          o_cull_count;
  triangle_assembler_state_t o_state;

  triangle_assembler dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_vertex_pixel  (v_px),
    .i_vertex_z      (v_z),
    .i_vertex_dv     (v_dv),
    .i_vertex_invalid(v_inv),
    .i_flush         (flush),
    .o_ready         (o_ready),
    .o_tri_pixel     (o_tri_pixel),
    .o_tri_z         (o_tri_z),
    .o_bbox_min      (o_bbox_min),
    .o_bbox_max      (o_bbox_max),
    .o_area          (o_area),
    .o_tri_dv        (o_tri_dv),
    .i_ready         (i_ready),
    .o_cull_count    (o_cull_count),
    .o_state         (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_exp;
  logic [PW-1:0] obs;
  int tests = 0;
  int fails = 0;
  int exp_cull = 0;

  assign obs = {o_tri_pixel[0][0], o_tri_pixel[0][1], o_tri_z[0],
                o_tri_pixel[1][0], o_tri_pixel[1][1], o_tri_z[1],
                o_tri_pixel[2][0], o_tri_pixel[2][1], o_tri_z[2],
                o_bbox_min[0], o_bbox_min[1], o_bbox_max[0], o_bbox_max[1], o_area};

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic int clip(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic void model(input int vx[3], input int vy[3], input int vz[3],
                                input bit inv, output logic [PW-1:0] e, output bit cull);
    longint area;
    int mnx, mxx, mny, mxy, t;
    int px[3][2];
    int pz[3];
    area = longint'(vx[1] - vx[0]) * longint'(vy[2] - vy[0])
         - longint'(vx[2] - vx[0]) * longint'(vy[1] - vy[0]);
    mnx = vx[0]; mxx = vx[0]; mny = vy[0]; mxy = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < mnx) mnx = vx[i];
      if (vx[i] > mxx) mxx = vx[i];
      if (vy[i] < mny) mny = vy[i];
      if (vy[i] > mxy) mxy = vy[i];
    end
    for (int i = 0; i < 3; i++) begin
      px[i][0] = vx[i]; px[i][1] = vy[i]; pz[i] = vz[i];
    end
    cull = inv || (area == 0) || (mxx < 0) || (mnx > SW - 1) || (mxy < 0) || (mny > SH - 1);
`ifdef TRIANGLE_ASSEMBLER_BACKFACE_CULL_EN
    if (area < 0) cull = 1'b1;
`else
    if (area < 0) begin
      area = -area;
      t = px[1][0]; px[1][0] = px[2][0]; px[2][0] = t;
      t = px[1][1]; px[1][1] = px[2][1]; px[2][1] = t;
      t = pz[1];    pz[1]    = pz[2];    pz[2]    = t;
    end
`endif
    e = {DW'(px[0][0]), DW'(px[0][1]), ZW'(pz[0]),
         DW'(px[1][0]), DW'(px[1][1]), ZW'(pz[1]),
         DW'(px[2][0]), DW'(px[2][1]), ZW'(pz[2]),
         DW'(clip(mnx, SW - 1)), DW'(clip(mny, SH - 1)),
         DW'(clip(mxx, SW - 1)), DW'(clip(mxy, SH - 1)), AW'(area)};
  endfunction

  always @(negedge clk) begin
    if (rstn && o_tri_dv && i_ready) begin
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_triangle");
      end else begin
        check("triangle_out", obs, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_vertex(input int x, input int y, input int z, input bit inv);
    int n;
    n = 0;
    v_px[0] = DW'(x); v_px[1] = DW'(y); v_z = ZW'(z); v_inv = inv; v_dv = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("vertex_accept");
    @(posedge clk);
    #1;
    v_dv = 1'b0; v_inv = 1'b0;
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input bit inv1);
    int vx[3];
    int vy[3];
    int vz[3];
    logic [PW-1:0] e;
    bit c;
    vx = '{x0, x1, x2};
    vy = '{y0, y1, y2};
    for (int i = 0; i < 3; i++) vz[i] = int'($urandom_range(0, 2047));
    model(vx, vy, vz, inv1, e, c);
    last_exp = e;
    if (c) exp_cull++;
    else exp_q.push_back(e);
    send_vertex(vx[0], vy[0], vz[0], 1'b0);
    send_vertex(vx[1], vy[1], vz[1], inv1);
    send_vertex(vx[2], vy[2], vz[2], 1'b0);
  endtask

  task automatic do_flush();
    v_px[0] = 12'sd7; v_px[1] = 12'sd9; v_z = 12'sd3; v_dv = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    v_dv = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(o_state == TA_COLLECT && exp_q.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail(tag);
    check({tag, "_cull_count"}, PW'(o_cull_count), PW'(exp_cull));
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; v_px[0] = '0; v_px[1] = '0; v_z = '0; v_dv = 1'b0; v_inv = 1'b0;
    flush = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tri_dv", PW'(o_tri_dv), PW'(0));
    check("reset_ready", PW'(o_ready), PW'(1));
    check("reset_state", PW'(o_state), PW'(TA_COLLECT));
    check("reset_outputs", obs, PW'(0));
    check("reset_cull_count", PW'(o_cull_count), PW'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic triangle and its two-cycle latency.
    send_tri(10, 10, 20, 10, 10, 20, 1'b0);
    check("latency_c1", PW'(o_tri_dv), PW'(0));
    @(posedge clk);
    #1;
    check("latency_c2", PW'(o_tri_dv), PW'(1));
    check("basic_area", PW'(o_area), PW'(100));
    check("basic_bbox", PW'({o_bbox_min[0], o_bbox_min[1], o_bbox_max[0], o_bbox_max[1]}),
          PW'({12'd10, 12'd10, 12'd20, 12'd20}));
    wait_idle("basic");

    // Clockwise winding: culled with back-face culling, re-wound otherwise.
    send_tri(10, 10, 10, 20, 20, 10, 1'b0);
    wait_idle("backface");

    // Collinear.
    send_tri(0, 0, 5, 5, 10, 10, 1'b0);
    wait_idle("collinear");

    // Clamped bbox, then fully off-screen.
    send_tri(-50, -5, 400, 10, 10, 330, 1'b0);
    wait_idle("clamp");
    send_tri(-30, 0, -10, 0, -20, 10, 1'b0);
    wait_idle("offscreen");

    // Invalid second vertex.
    send_tri(30, 30, 60, 30, 30, 60, 1'b1);
    wait_idle("invalid");

    // Flush after two vertices (second one invalid); colliding vertex dropped.
    send_vertex(100, 100, 5, 1'b0);
    send_vertex(200, 100, 6, 1'b1);
    do_flush();
    send_tri(50, 50, 80, 50, 50, 90, 1'b0);
    wait_idle("flush");

    // Random triangles.
    for (int k = 0; k < 6; k++) begin
      send_tri(int'($urandom_range(0, 360)) - 20, int'($urandom_range(0, 360)) - 20,
               int'($urandom_range(0, 360)) - 20, int'($urandom_range(0, 360)) - 20,
               int'($urandom_range(0, 360)) - 20, int'($urandom_range(0, 360)) - 20, 1'b0);
      wait_idle("random");
    end

    // Output stall: payload held, no vertex accepted.
    i_ready = 1'b0;
    send_tri(5, 5, 40, 8, 12, 44, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_tri_dv", PW'(o_tri_dv), PW'(1));
      check("stall_ready", PW'(o_ready), PW'(0));
      check("stall_payload", obs, last_exp);
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    wait_idle("stall");

    // Reset during a stall discards the pending triangle.
    i_ready = 1'b0;
    send_vertex(10, 10, 1, 1'b0);
    send_vertex(20, 10, 2, 1'b0);
    send_vertex(10, 20, 3, 1'b0);
    @(posedge clk);
    #1;
    check("prereset_tri_dv", PW'(o_tri_dv), PW'(1));
    rstn = 1'b0;
    #1;
    check("midreset_tri_dv", PW'(o_tri_dv), PW'(0));
    check("midreset_outputs", obs, PW'(0));
    check("midreset_cull_count", PW'(o_cull_count), PW'(0));
    check("midreset_state", PW'(o_state), PW'(TA_COLLECT));
    exp_cull = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    i_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("postreset_tri_dv", PW'(o_tri_dv), PW'(0));
    check("postreset_ready", PW'(o_ready), PW'(1));

    check("queue_empty", PW'(exp_q.size()), PW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
